// File: rtl/flag_pkg.sv
// flag_pkg: shared types and constants for the flag painters and the slideshow scheduler
package flag_pkg;
  localparam int CORDW = 10;
  typedef logic [3:0] chan_t;
  typedef struct packed {
    chan_t r;
    chan_t g;
    chan_t b;
  } rgb_t;
  typedef enum logic [1:0] {HOLD, WIPE, PAUSED} show_state_t;
endpackage

// File: rtl/rise_detect.sv
// rise_detect: one-cycle pulse on a rising level; a level already high when reset ends never pulses
module rise_detect (
  input  logic clk_pix,
  input  logic rst_pix_n,
  input  logic in,
  output logic out
);
  logic prev_q, prev_d, arm_q, arm_d;
  // capture the previous level; arm only after the first post-reset sample so a held button is ignored
  always_comb begin
    prev_d = in;
    arm_d  = 1'b1;
  end
  // edge history registers
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      prev_q <= 1'b0;
      arm_q  <= 1'b0;
    end else begin
      prev_q <= prev_d;
      arm_q  <= arm_d;
    end
  end
  assign out = arm_q & in & ~prev_q;
endmodule

// File: rtl/flag_show_sched.sv
// flag_show_sched: slideshow scheduler with hold, left-to-right wipe, user advance and pause
module flag_show_sched
  import flag_pkg::*;
#(
  parameter int NFLAGS      = 4,
  parameter int HOLD_FRAMES = 300,
  parameter int WIPE_STEP   = 8,
  parameter int H_RES       = 640
) (
  input  logic                      clk_pix,
  input  logic                      rst_pix_n,
  input  logic [CORDW-1:0]          sx,
  input  logic [CORDW-1:0]          sy,
  input  logic                      de,
  input  logic                      frame,
  input  logic                      btn_next,
  input  logic                      btn_pause,
  input  logic [4*NFLAGS-1:0]       flag_r,
  input  logic [4*NFLAGS-1:0]       flag_g,
  input  logic [4*NFLAGS-1:0]       flag_b,
  output logic [3:0]                paint_r,
  output logic [3:0]                paint_g,
  output logic [3:0]                paint_b,
  output logic [$clog2(NFLAGS)-1:0] flag_sel,
  output logic                      wiping,
  output logic                      paused
);
  localparam int SW  = $clog2(NFLAGS);
  localparam int FCW = $clog2(HOLD_FRAMES) + 1;
  show_state_t     state_q, state_d;
  logic [SW-1:0]    cur_q, cur_d, nxt, pix_sel;
  logic [FCW-1:0]   cnt_q, cnt_d;
  logic [CORDW-1:0] wipe_x_q, wipe_x_d;
  logic             pend_q, pend_d, pend_t;
  rgb_t             paint_q, paint_d;
  rgb_t             pal [2**SW];
  logic             next_evt, pause_evt, wipe_done, expire;
  logic [CORDW:0]   wipe_sum;
  logic             unused_sy;
  assign unused_sy = ^sy;
  rise_detect u_next (.clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .in(btn_next), .out(next_evt));
  rise_detect u_pause (.clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .in(btn_pause), .out(pause_evt));
  for (genvar i = 0; i < 2**SW; i++) begin : g_pal
    if (i < NFLAGS) begin : g_real
      assign pal[i] = '{r: flag_r[4*i +: 4], g: flag_g[4*i +: 4], b: flag_b[4*i +: 4]};
    end else begin : g_pad
      assign pal[i] = '0;
    end
  end
  assign nxt       = (cur_q == SW'(NFLAGS - 1)) ? '0 : cur_q + 1'b1;
  assign wipe_sum  = {1'b0, wipe_x_q} + (CORDW + 1)'(WIPE_STEP);
  assign wipe_done = wipe_sum >= (CORDW + 1)'(H_RES);
  assign expire    = frame && (cnt_q == FCW'(HOLD_FRAMES - 1));
  assign pend_t    = pend_q ^ pause_evt;
  // slideshow sequencing: pause beats advance/expiry in HOLD, a pause during a wipe is deferred
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    cnt_d    = cnt_q;
    wipe_x_d = wipe_x_q;
    pend_d   = pend_q;
    case (state_q)
      HOLD: begin
        if (pause_evt) state_d = PAUSED;
        else if (next_evt || expire) begin
          state_d  = WIPE;
          wipe_x_d = '0;
          cnt_d    = '0;
        end else if (frame) cnt_d = cnt_q + 1'b1;
      end
      WIPE: begin
        pend_d = pend_t;
        if (frame && wipe_done) begin
          cur_d    = nxt;
          wipe_x_d = '0;
          cnt_d    = '0;
          state_d  = pend_t ? PAUSED : HOLD;
          pend_d   = 1'b0;
        end else if (frame) wipe_x_d = wipe_sum[CORDW-1:0];
      end
      PAUSED: begin
        if (pause_evt) state_d = HOLD;
        else if (next_evt) begin
          cur_d = nxt;
          cnt_d = '0;
        end
      end
      default: state_d = HOLD;
    endcase
  end
  // pixel colour: left of the wipe edge shows the incoming flag, blanking outside the active region
  always_comb begin
    pix_sel = (state_q == WIPE && sx < wipe_x_q) ? nxt : cur_q;
    paint_d = de ? pal[pix_sel] : '0;
  end
  // state and pixel registers
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      state_q  <= HOLD;
      cur_q    <= '0;
      cnt_q    <= '0;
      wipe_x_q <= '0;
      pend_q   <= 1'b0;
      paint_q  <= '0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      cnt_q    <= cnt_d;
      wipe_x_q <= wipe_x_d;
      pend_q   <= pend_d;
      paint_q  <= paint_d;
    end
  end
  assign paint_r  = paint_q.r;
  assign paint_g  = paint_q.g;
  assign paint_b  = paint_q.b;
  assign flag_sel = cur_q;
  assign wiping   = state_q == WIPE;
  assign paused   = state_q == PAUSED;
endmodule

// File: tb/tb_flag_show_sched.sv
// tb_flag_show_sched: scoreboard bench for the flag slideshow scheduler
module tb_flag_show_sched;
  logic       clk_pix = 1'b0;
  logic       rst_pix_n = 1'b0;
  logic [9:0] sx = '0, sy = '0;
  logic       de = 1'b0, frame = 1'b0, btn_next = 1'b0, btn_pause = 1'b0;
  logic [11:0] flag_r, flag_g, flag_b;
  logic [3:0] paint_r, paint_g, paint_b;
  logic [1:0] flag_sel;
  logic       wiping, paused;
  logic [15:0] exp_q [$];
  logic [15:0] e;
  int total = 0, bad = 0;

  assign flag_r = {4'd3, 4'd2, 4'd1};
  assign flag_g = '0;
  assign flag_b = '0;

  flag_show_sched #(.NFLAGS(3), .HOLD_FRAMES(3), .WIPE_STEP(160), .H_RES(640)) dut (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .sx(sx), .sy(sy), .de(de), .frame(frame),
    .btn_next(btn_next), .btn_pause(btn_pause), .flag_r(flag_r), .flag_g(flag_g), .flag_b(flag_b),
    .paint_r(paint_r), .paint_g(paint_g), .paint_b(paint_b), .flag_sel(flag_sel),
    .wiping(wiping), .paused(paused)
  );

  always #5 clk_pix = ~clk_pix;

  function automatic logic [15:0] obs();
    return {flag_sel, wiping, paused, paint_r, paint_g, paint_b};
  endfunction

  function automatic logic [15:0] ev(input logic [1:0] s, input logic w, input logic p, input logic [3:0] r);
    return {s, w, p, r, 8'h00};
  endfunction

  task automatic tick();
    @(posedge clk_pix);
    #1;
  endtask

  task automatic strobe();
    frame = 1'b1;
    tick();
    frame = 1'b0;
  endtask

  task automatic test_reset();
    btn_next = 1'b1; btn_pause = 1'b1;
    exp_q.push_back(ev(0, 0, 0, 0));
    tick(); tick();
    e = exp_q.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL reset got=%h want=%h", obs(), e); end
    exp_q.push_back(ev(0, 0, 0, 0));
    rst_pix_n = 1'b1;
    repeat (3) tick();
    e = exp_q.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL held_btn got=%h want=%h", obs(), e); end
    btn_next = 1'b0; btn_pause = 1'b0;
    tick();
  endtask

  task automatic test_auto_wipe();
    exp_q.push_back(ev(0, 1, 0, 0));
    repeat (3) strobe();
    e = exp_q.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL auto_wipe_start got=%h want=%h", obs(), e); end
    repeat (2) strobe();
    exp_q.push_back(ev(0, 1, 0, 2));
    de = 1'b1; sx = 10'd319; tick();
    e = exp_q.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL pix_left got=%h want=%h", obs(), e); end
    exp_q.push_back(ev(0, 1, 0, 1));
    sx = 10'd320; tick();
    e = exp_q.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL pix_right got=%h want=%h", obs(), e); end
    exp_q.push_back(ev(0, 1, 0, 0));
    de = 1'b0; tick();
    e = exp_q.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL pix_blank got=%h want=%h", obs(), e); end
    exp_q.push_back(ev(1, 0, 0, 0));
    repeat (2) strobe();
    e = exp_q.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL auto_wipe_done got=%h want=%h", obs(), e); end
  endtask

  task automatic test_wrap();
    exp_q.push_back(ev(2, 0, 0, 0));
    repeat (7) strobe();
    e = exp_q.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL wrap_to_2 got=%h want=%h", obs(), e); end
    exp_q.push_back(ev(0, 0, 0, 0));
    repeat (7) strobe();
    e = exp_q.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL wrap_to_0 got=%h want=%h", obs(), e); end
  endtask

  task automatic test_next_btn();
    strobe();
    exp_q.push_back(ev(0, 1, 0, 0));
    btn_next = 1'b1; tick();
    e = exp_q.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL next_start got=%h want=%h", obs(), e); end
    exp_q.push_back(ev(0, 1, 0, 0));
    repeat (9) tick();
    e = exp_q.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL next_held got=%h want=%h", obs(), e); end
    exp_q.push_back(ev(1, 0, 0, 0));
    repeat (4) strobe();
    e = exp_q.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL next_done got=%h want=%h", obs(), e); end
    exp_q.push_back(ev(1, 0, 0, 0));
    repeat (3) tick();
    e = exp_q.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL next_no_rewipe got=%h want=%h", obs(), e); end
    btn_next = 1'b0; tick();
    repeat (2) strobe();
    exp_q.push_back(ev(1, 1, 0, 0));
    frame = 1'b1; btn_next = 1'b1; tick(); frame = 1'b0; btn_next = 1'b0;
    e = exp_q.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL coincide_start got=%h want=%h", obs(), e); end
    exp_q.push_back(ev(2, 0, 0, 0));
    repeat (4) strobe();
    e = exp_q.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL coincide_done got=%h want=%h", obs(), e); end
  endtask

  task automatic test_pause();
    strobe();
    exp_q.push_back(ev(2, 0, 1, 0));
    btn_pause = 1'b1; tick(); btn_pause = 1'b0;
    e = exp_q.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL pause_enter got=%h want=%h", obs(), e); end
    exp_q.push_back(ev(2, 0, 1, 0));
    repeat (20) strobe();
    e = exp_q.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL pause_frozen got=%h want=%h", obs(), e); end
    exp_q.push_back(ev(2, 0, 0, 0));
    btn_pause = 1'b1; tick(); btn_pause = 1'b0;
    e = exp_q.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL pause_resume got=%h want=%h", obs(), e); end
    exp_q.push_back(ev(2, 0, 0, 0));
    strobe();
    e = exp_q.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL resume_cnt got=%h want=%h", obs(), e); end
    exp_q.push_back(ev(2, 1, 0, 0));
    strobe();
    e = exp_q.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL resume_expire got=%h want=%h", obs(), e); end
    exp_q.push_back(ev(2, 1, 0, 0));
    btn_pause = 1'b1; tick(); btn_pause = 1'b0;
    e = exp_q.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL pause_in_wipe got=%h want=%h", obs(), e); end
    exp_q.push_back(ev(2, 1, 0, 0));
    repeat (3) strobe();
    e = exp_q.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL wipe_continues got=%h want=%h", obs(), e); end
    exp_q.push_back(ev(0, 0, 1, 0));
    strobe();
    e = exp_q.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL wipe_then_pause got=%h want=%h", obs(), e); end
  endtask

  task automatic test_paused_next();
    exp_q.push_back(ev(1, 0, 1, 0));
    btn_next = 1'b1; tick(); btn_next = 1'b0;
    e = exp_q.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL paused_cut got=%h want=%h", obs(), e); end
    exp_q.push_back(ev(1, 0, 1, 0));
    repeat (5) strobe();
    e = exp_q.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL paused_ignores_frame got=%h want=%h", obs(), e); end
    btn_pause = 1'b1; tick(); btn_pause = 1'b0;
    exp_q.push_back(ev(1, 1, 0, 0));
    repeat (3) strobe();
    e = exp_q.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL cut_then_wipe got=%h want=%h", obs(), e); end
    strobe();
    exp_q.push_back(ev(1, 1, 0, 3));
    de = 1'b1; sx = 10'd0; tick();
    e = exp_q.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL pre_reset_pix got=%h want=%h", obs(), e); end
    exp_q.push_back(ev(0, 0, 0, 0));
    #2 rst_pix_n = 1'b0;
    #1;
    e = exp_q.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL async_reset got=%h want=%h", obs(), e); end
    de = 1'b0; tick();
    rst_pix_n = 1'b1;
    exp_q.push_back(ev(0, 0, 0, 0));
    repeat (2) tick();
    repeat (2) strobe();
    e = exp_q.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL wipe_abandoned got=%h want=%h", obs(), e); end
  endtask

  task automatic test_back_to_back();
    exp_q.push_back(ev(0, 0, 1, 0));
    btn_pause = 1'b1; btn_next = 1'b1; tick(); btn_pause = 1'b0; btn_next = 1'b0;
    e = exp_q.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL pause_priority got=%h want=%h", obs(), e); end
    exp_q.push_back(ev(0, 0, 1, 0));
    repeat (2) tick();
    e = exp_q.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL pause_stable got=%h want=%h", obs(), e); end
  endtask

  initial begin
    test_reset();
    test_auto_wipe();
    test_wrap();
    test_next_btn();
    test_pause();
    test_paused_next();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/flag_show_sched.md
Name: flag_show_sched

Overview:
- Schedules a slideshow across NFLAGS combinational flag painters that all share the same sx/sy pixel stream.
- Holds the current flag for HOLD_FRAMES frames, then performs a left-to-right wipe to the next flag.
- Supports user advance and pause.
- Sits between the flag painters and the display output stage, and drives the final registered pixel colour.

Parameters:
- NFLAGS, 4, number of flag painters (2..16).
- HOLD_FRAMES, 300, frames each flag is shown before an automatic wipe (≥1).
- WIPE_STEP, 8, pixels the wipe edge advances per frame (1..H_RES).
- H_RES, 640, active horizontal resolution.

Ports:
- clk_pix  in  1  pixel clock.
- rst_pix_n  in  1  asynchronous active-low reset.
- sx  in  CORDW(10)  screen x.
- sy  in  CORDW(10)  screen y; unused except for alignment.
- de  in  1  data enable, active region.
- frame  in  1  one-cycle strobe at frame start.
- btn_next  in  1  debounced level; its rising edge requests advance.
- btn_pause  in  1  debounced level; its rising edge toggles pause.
- flag_r  in  4*NFLAGS  painter red outputs; flag i is at [4*i +: 4]. flag_g and flag_b use the same layout.
- flag_g  in  4*NFLAGS  painter green outputs.
- flag_b  in  4*NFLAGS  painter blue outputs.
- paint_r  out  4  registered red.
- paint_g  out  4  registered green.
- paint_b  out  4  registered blue.
- flag_sel  out  $clog2(NFLAGS)  index of the current flag.
- wiping  out  1  high while in WIPE.
- paused  out  1  high while in PAUSED.

Behaviour:
- Reset (async, rst_pix_n low) clears all of the following:
  - state=HOLD, cur=0, nxt=1, frame_cnt=0, wipe_x=0, pause_pend=0.
  - paint_* = 0, flag_sel=0, wiping=0, paused=0.
  - Button edge registers cleared, so a button held through reset produces no edge.
  - Reset mid-wipe abandons the wipe.
- Edge detect: the registered previous level gives next_evt = btn_next & ~prev, and likewise pause_evt.
- nxt is always (cur==NFLAGS-1) ? 0 : cur+1, i.e. wrap-around.
- HOLD:
  - On frame: if frame_cnt==HOLD_FRAMES-1, go to WIPE with wipe_x=0 and frame_cnt=0; else frame_cnt++.
  - On next_evt: go to WIPE with wipe_x=0 and frame_cnt=0.
  - If frame at expiry and next_evt coincide, exactly one wipe starts.
  - On pause_evt: go to PAUSED; frame_cnt is frozen. pause_evt takes priority over next_evt and expiry in the same cycle.
- WIPE:
  - On frame: if wipe_x+WIPE_STEP >= H_RES, set cur=nxt, wipe_x=0, frame_cnt=0, then go to PAUSED if pause_pend else HOLD, and clear pause_pend. Otherwise wipe_x += WIPE_STEP.
  - The sum is computed at CORDW+1 bits, so there is no overflow.
  - next_evt is ignored.
  - pause_evt toggles pause_pend, so the pause takes effect after the wipe completes.
- PAUSED:
  - frame is ignored.
  - On pause_evt: go to HOLD, resuming the frozen frame_cnt.
  - On next_evt: immediate cut with cur=nxt and frame_cnt=0; stay in PAUSED.
- wipe_x changes only on the frame strobe, so it is stable across the whole visible frame.
- Pixel path, 1-cycle latency: on each clk_pix, the output registers sample a colour as follows:
  - de=0 → 0.
  - de=1, state==WIPE and sx<wipe_x → flag nxt.
  - de=1 otherwise → flag cur.
  - Consumers must delay sx/sy/de by one cycle to align with paint_*.
- flag_sel, wiping and paused are registered and reflect the state after each edge.

Decomposition:
- Package flag_pkg holds the following; all flag painters and this block import it:
  - localparam CORDW=10.
  - typedef logic [3:0] chan_t.
  - typedef struct packed {chan_t r,g,b;} rgb_t.
  - typedef enum logic [1:0] {HOLD, WIPE, PAUSED} show_state_t.
- One sub-module, rise_detect: parameterless, clk_pix, rst_pix_n, in level → out one-cycle pulse. It is instanced twice.

Test Plan:
All tests use NFLAGS=3, HOLD_FRAMES=3, WIPE_STEP=160, H_RES=640. Painter i outputs a constant colour r=i+1, g=0, b=0.
1. Reset, then 3 frame strobes → wiping=1, wipe_x=0, cur=0. After 4 more strobes → flag_sel=1, wiping=0.
2. Mid-wipe with wipe_x=320:
   - de=1, sx=319 → paint_r=2 one cycle later.
   - sx=320 → paint_r=1.
   - de=0 → paint_r=0.
3. Wrap-around: auto-advance through flag 2 → flag_sel returns to 0.
4. btn_next rise in HOLD at frame_cnt=1 → wiping=1 next cycle. A btn_next held high for 10 cycles yields only one wipe.
5. Pause paths:
   - btn_pause rise in HOLD at frame_cnt=1 → 20 frame strobes, flag_sel unchanged. Second rise, then 2 strobes → wiping=1.
   - btn_pause rise during WIPE → wipe completes, then paused=1.
6. In PAUSED, btn_next rise → flag_sel advances immediately and wiping stays 0. Assert rst_pix_n mid-wipe → all outputs 0 asynchronously, flag_sel=0.
